subtraction_fp_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision subtractor. Computes Diff = InA - InB.
- Companion to the combinational FP adder. It provides the reverse operation for Q-learning TD-error (target - Q) and Q-value updates.
- Uses a valid/ready handshake and normalizes one bit per cycle, so it needs no wide combinational shifter loop.
- Sits between the Q-table read path and the multiplier/adder update stage.

---
 rtl/fp_pkg.sv | 46 ++++
 rtl/fp_align_shift.sv | 45 ++++
 rtl/subtraction_fp_seq.sv | 271 +++++++++++++++++++++++++++
 tb/tb_subtraction_fp_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the sequential single-precision subtractor.
//   - IEEE-754 single field positions and special constants
//   - FSM state encoding
//   - working mantissa width: 24 bits, or 27 bits (24 + guard/round/sticky)
//     when FP_SUB_ROUND_EN is defined
//   - significand(): unpacks the significand with the hidden bit; exponent 0
//     flushes the operand to zero (denormals are not supported)
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'd255;
  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

`ifdef FP_SUB_ROUND_EN
  localparam int GRS_W = 3;
`else
  localparam int GRS_W = 0;
`endif

  // Working mantissa: hidden bit + fraction (+ guard/round/sticky).
  localparam int WORK_W = MANT_W + 1 + GRS_W;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NORM,
    DONE
  } state_t;

  function automatic logic [MANT_W:0] significand(input logic [31:0] f);
    logic [MANT_W:0] s;
    if (f[EXP_MSB:EXP_LSB] == 8'd0) begin
      s = {(MANT_W + 1){1'b0}};
    end else begin
      s = {1'b1, f[MANT_W-1:0]};
    end
    return s;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: right-shifts a 24-bit significand by an 8-bit exponent
// difference for operand alignment.
// Ports:
//   mant     in  24  significand to align
//   amt      in  8   shift distance (exponent difference)
//   mant_out out 24  aligned significand, forced to 0 for amt >= 25
//   guard    out 1   first bit shifted out below the LSB
//   round    out 1   second bit shifted out below the LSB
//   sticky   out 1   OR of every remaining bit shifted out
// guard/round/sticky are only consumed when FP_SUB_ROUND_EN is defined.
module fp_align_shift
  import fp_pkg::*;
(
  input  logic [MANT_W:0] mant,
  input  logic [7:0]      amt,
  output logic [MANT_W:0] mant_out,
  output logic            guard,
  output logic            round,
  output logic            sticky
);

  // Layout: [mantissa][guard][round][26-bit sticky window].
  localparam int EXT_W = MANT_W + 1 + 28;

  logic [7:0]       amt_cap_s;
  logic [EXT_W-1:0] ext_s;
  logic [EXT_W-1:0] shifted_s;

  // Shift with the distance capped at 26: beyond that every mantissa bit is
  // already inside the sticky window, so a longer shift changes nothing.
  always_comb begin
    amt_cap_s = (amt > 8'd26) ? 8'd26 : amt;
    ext_s     = {mant, 28'd0};
    shifted_s = ext_s >> amt_cap_s;
    if (amt >= 8'd25) begin
      mant_out = {(MANT_W + 1){1'b0}};
    end else begin
      mant_out = shifted_s[EXT_W-1:28];
    end
    guard  = shifted_s[27];
    round  = shifted_s[26];
    sticky = |shifted_s[25:0];
  end

endmodule

// File: rtl/subtraction_fp_seq.sv
// subtraction_fp_seq: multi-cycle IEEE-754 single-precision subtractor,
// Diff = InA - InB, computed as InA + (-InB).
// Sequence: IDLE -> ALIGN -> SUB -> NORM (one shift per cycle) -> DONE.
// Exponent 0 operands are zero, exponent 255 is not special-cased, and the
// default rounding is truncation. Defining FP_SUB_ROUND_EN carries
// guard/round/sticky bits and rounds to nearest-even in a two-cycle DONE.
// Ports:
//   clk       in  1   rising-edge clock
//   rst       in  1   synchronous active-high reset
//   in_valid  in  1   operands present
//   in_ready  out 1   idle, operands accepted on in_valid & in_ready
//   InA       in  32  minuend
//   InB       in  32  subtrahend
//   out_valid out 1   one-cycle pulse with a new Diff
//   Diff      out 32  result, held until the next result
module subtraction_fp_seq
  import fp_pkg::*;
#(
  parameter int MAX_NORM_SHIFTS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] InA,
  input  logic [31:0] InB,
  output logic        out_valid,
  output logic [31:0] Diff
);

  localparam logic [7:0]        MAX_SHIFT_C = 8'(MAX_NORM_SHIFTS);
  localparam logic [WORK_W-1:0] WORK_ZERO   = {WORK_W{1'b0}};

  state_t            state_r,     state_nxt;
  logic [31:0]       a_r,         a_nxt;
  logic [31:0]       b_r,         b_nxt;
  logic              sign_r,      sign_nxt;
  logic [7:0]        exp_r,       exp_nxt;
  logic              eff_add_r,   eff_add_nxt;
  logic [WORK_W-1:0] mant_r,      mant_nxt;
  logic [WORK_W-1:0] small_r,     small_nxt;
  logic [7:0]        shift_cnt_r, shift_cnt_nxt;
  logic              in_ready_r,  in_ready_nxt;
  logic              out_valid_r, out_valid_nxt;
  logic [31:0]       diff_r,      diff_nxt;
`ifdef FP_SUB_ROUND_EN
  logic              rounded_r,   rounded_nxt;
  logic              round_up_s;
  logic [MANT_W+1:0] round_sum_s;
`endif

  logic [7:0]        exp_a_s, exp_b_s, big_exp_s, align_amt_s;
  logic [MANT_W:0]   sig_a_s, sig_b_s, big_sig_s, lil_sig_s, lil_shift_s;
  logic              a_big_s, big_sign_s;
  logic              guard_s, round_s, sticky_s;
  logic [WORK_W:0]   sum_s;
  logic [WORK_W-1:0] dif_s, carry_mant_s, big_work_s, lil_work_s;

  // Operand decode: the larger magnitude sets sign and exponent, the smaller
  // one is aligned to it.
  always_comb begin
    exp_a_s = a_r[EXP_MSB:EXP_LSB];
    exp_b_s = b_r[EXP_MSB:EXP_LSB];
    sig_a_s = significand(a_r);
    sig_b_s = significand(b_r);
    a_big_s = (exp_a_s > exp_b_s) || ((exp_a_s == exp_b_s) && (sig_a_s >= sig_b_s));
    if (a_big_s) begin
      big_sign_s  = a_r[SIGN_BIT];
      big_exp_s   = exp_a_s;
      big_sig_s   = sig_a_s;
      lil_sig_s   = sig_b_s;
      align_amt_s = exp_a_s - exp_b_s;
    end else begin
      big_sign_s  = b_r[SIGN_BIT];
      big_exp_s   = exp_b_s;
      big_sig_s   = sig_b_s;
      lil_sig_s   = sig_a_s;
      align_amt_s = exp_b_s - exp_a_s;
    end
  end

  fp_align_shift u_align (
    .mant     (lil_sig_s),
    .amt      (align_amt_s),
    .mant_out (lil_shift_s),
    .guard    (guard_s),
    .round    (round_s),
    .sticky   (sticky_s)
  );

  // Mantissa arithmetic for SUB; a carry-out renormalises right by one.
  always_comb begin
    sum_s = {1'b0, mant_r} + {1'b0, small_r};
    dif_s = mant_r - small_r;
`ifdef FP_SUB_ROUND_EN
    // The bit dropped by the right shift folds into sticky.
    carry_mant_s = {sum_s[WORK_W:2], sum_s[1] | sum_s[0]};
    big_work_s   = {big_sig_s, 3'b000};
    lil_work_s   = {lil_shift_s, guard_s, round_s, sticky_s};
    round_up_s   = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
    round_sum_s  = {1'b0, mant_r[WORK_W-1:3]} + {{(MANT_W + 1){1'b0}}, round_up_s};
`else
    carry_mant_s = sum_s[WORK_W:1];
    big_work_s   = big_sig_s;
    lil_work_s   = lil_shift_s;
`endif
  end

`ifndef FP_SUB_ROUND_EN
  logic grs_unused_s;
  assign grs_unused_s = guard_s ^ round_s ^ sticky_s;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state_r;
    a_nxt         = a_r;
    b_nxt         = b_r;
    sign_nxt      = sign_r;
    exp_nxt       = exp_r;
    eff_add_nxt   = eff_add_r;
    mant_nxt      = mant_r;
    small_nxt     = small_r;
    shift_cnt_nxt = shift_cnt_r;
    in_ready_nxt  = in_ready_r;
    out_valid_nxt = 1'b0;
    diff_nxt      = diff_r;
`ifdef FP_SUB_ROUND_EN
    rounded_nxt   = rounded_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          a_nxt        = InA;
          b_nxt        = {~InB[SIGN_BIT], InB[SIGN_BIT-1:0]};
          in_ready_nxt = 1'b0;
          state_nxt    = ALIGN;
        end else begin
          state_nxt = IDLE;
        end
      end
      ALIGN: begin
        sign_nxt    = big_sign_s;
        exp_nxt     = big_exp_s;
        mant_nxt    = big_work_s;
        small_nxt   = lil_work_s;
        // Same sign after negating B means the magnitudes add.
        eff_add_nxt = (a_r[SIGN_BIT] == b_r[SIGN_BIT]);
        state_nxt   = SUB;
      end
      SUB: begin
        shift_cnt_nxt = 8'd0;
        if (eff_add_r && sum_s[WORK_W] && (exp_r >= 8'd254)) begin
          exp_nxt   = EXP_MAX;
          mant_nxt  = WORK_ZERO;
          state_nxt = DONE;
        end else if (eff_add_r && sum_s[WORK_W]) begin
          mant_nxt  = carry_mant_s;
          exp_nxt   = exp_r + 8'd1;
          state_nxt = NORM;
        end else if (eff_add_r && (sum_s[WORK_W-1:0] == WORK_ZERO)) begin
          sign_nxt  = 1'b0;
          exp_nxt   = 8'd0;
          mant_nxt  = WORK_ZERO;
          state_nxt = DONE;
        end else if (eff_add_r) begin
          mant_nxt  = sum_s[WORK_W-1:0];
          state_nxt = NORM;
        end else if (dif_s == WORK_ZERO) begin
          sign_nxt  = 1'b0;
          exp_nxt   = 8'd0;
          mant_nxt  = WORK_ZERO;
          state_nxt = DONE;
        end else begin
          mant_nxt  = dif_s;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (mant_r[WORK_W-1]) begin
          state_nxt = DONE;
        end else if ((exp_r == 8'd1) || (shift_cnt_r >= MAX_SHIFT_C)) begin
          // Underflow flushes to +0; no denormal output.
          sign_nxt  = 1'b0;
          exp_nxt   = 8'd0;
          mant_nxt  = WORK_ZERO;
          state_nxt = DONE;
        end else begin
          mant_nxt      = {mant_r[WORK_W-2:0], 1'b0};
          exp_nxt       = exp_r - 8'd1;
          shift_cnt_nxt = shift_cnt_r + 8'd1;
          state_nxt     = NORM;
        end
      end
      DONE: begin
`ifdef FP_SUB_ROUND_EN
        if (!rounded_r) begin
          rounded_nxt = 1'b1;
          state_nxt   = DONE;
          if (round_sum_s[MANT_W+1] && (exp_r >= 8'd254)) begin
            exp_nxt  = EXP_MAX;
            mant_nxt = WORK_ZERO;
          end else if (round_sum_s[MANT_W+1]) begin
            mant_nxt = {round_sum_s[MANT_W+1:1], 3'b000};
            exp_nxt  = exp_r + 8'd1;
          end else begin
            mant_nxt = {round_sum_s[MANT_W:0], 3'b000};
          end
        end else begin
          rounded_nxt   = 1'b0;
          diff_nxt      = {sign_r, exp_r, mant_r[WORK_W-2 -: MANT_W]};
          out_valid_nxt = 1'b1;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
`else
        diff_nxt      = {sign_r, exp_r, mant_r[WORK_W-2 -: MANT_W]};
        out_valid_nxt = 1'b1;
        in_ready_nxt  = 1'b1;
        state_nxt     = IDLE;
`endif
      end
      default: begin
        in_ready_nxt = 1'b1;
        state_nxt    = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      sign_r      <= 1'b0;
      exp_r       <= 8'd0;
      eff_add_r   <= 1'b0;
      mant_r      <= WORK_ZERO;
      small_r     <= WORK_ZERO;
      shift_cnt_r <= 8'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      diff_r      <= FP_ZERO;
`ifdef FP_SUB_ROUND_EN
      rounded_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt;
      a_r         <= a_nxt;
      b_r         <= b_nxt;
      sign_r      <= sign_nxt;
      exp_r       <= exp_nxt;
      eff_add_r   <= eff_add_nxt;
      mant_r      <= mant_nxt;
      small_r     <= small_nxt;
      shift_cnt_r <= shift_cnt_nxt;
      in_ready_r  <= in_ready_nxt;
      out_valid_r <= out_valid_nxt;
      diff_r      <= diff_nxt;
`ifdef FP_SUB_ROUND_EN
      rounded_r   <= rounded_nxt;
`endif
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Diff      = diff_r;

endmodule

// File: tb/tb_subtraction_fp_seq.sv
// Self-checking bench for subtraction_fp_seq: directed cases, busy/reset
// behaviour and randomized operands against a behavioural model.
module tb_subtraction_fp_seq;
  import fp_pkg::*;

`ifdef FP_SUB_ROUND_EN
  localparam int DONE_CYC = 2;
`else
  localparam int DONE_CYC = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] InA;
  logic [31:0] InB;
  logic        out_valid;
  logic [31:0] Diff;

  int errors;
  int checks;

  subtraction_fp_seq #(.MAX_NORM_SHIFTS(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .InA       (InA),
    .InB       (InB),
    .out_valid (out_valid),
    .Diff      (Diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: A - B as A + (-B) on integer significands, smaller operand
  // truncated to the larger exponent, then normalised. lat is the number of
  // clock edges from accept to out_valid.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                          output int lat);
    logic        sa, sb, sl;
    int          ea, eb, el, d, k;
    logic [63:0] ma, mb, ml, ms, sh, r, top, m;
    sa = a[31];
    sb = ~b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 64'd0 : {40'd0, 1'b1, a[22:0]};
    mb = (eb == 0) ? 64'd0 : {40'd0, 1'b1, b[22:0]};
    if (ea > eb || (ea == eb && ma >= mb)) begin
      sl = sa; el = ea; ml = ma; ms = mb; d = ea - eb;
    end else begin
      sl = sb; el = eb; ml = mb; ms = ma; d = eb - ea;
    end
    sh = (d >= 64) ? 64'd0 : ((ms << 40) >> d);
`ifdef FP_SUB_ROUND_EN
    ms = sh >> 37;
    if ((sh & ((64'd1 << 37) - 64'd1)) != 64'd0) ms = ms | 64'd1;
    ml = ml << 3;
    top = 64'd1 << 26;
`else
    ms = sh >> 40;
    top = 64'd1 << 23;
`endif
    r = (sa == sb) ? (ml + ms) : (ml - ms);
    lat = 2 + DONE_CYC;
    if (r == 64'd0) return 32'h0000_0000;
    if (r >= (top << 1)) begin
      if (el + 1 >= 255) return {sl, 8'hFF, 23'd0};
`ifdef FP_SUB_ROUND_EN
      r = (r >> 1) | (r & 64'd1);
`else
      r = r >> 1;
`endif
      el++;
    end
    k = 0;
    while (r < top) begin
      if (el - 1 == 0) begin
        lat = 3 + k + DONE_CYC;
        return 32'h0000_0000;
      end
      r = r << 1;
      el--;
      k++;
    end
    lat = 3 + k + DONE_CYC;
`ifdef FP_SUB_ROUND_EN
    m = r >> 3;
    if (r[2] && (r[1] || r[0] || m[0])) m = m + 64'd1;
    if (m[24]) begin
      m = m >> 1;
      if (el + 1 >= 255) return {sl, 8'hFF, 23'd0};
      el++;
    end
`else
    m = r;
`endif
    return {sl, el[7:0], m[22:0]};
  endfunction

  // One transaction: accept, wait (bounded) for out_valid, check result,
  // latency and that the pulse lasts a single cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int lat);
    int n;
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    InA = a;
    InB = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    InA = $urandom;
    InB = $urandom;
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " diff"}, Diff, expv);
    check({tag, " ready at valid"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check({tag, " pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          n, bad, lat, ea;
    logic [31:0] a, b, e;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    InA      = 32'd0;
    InB      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset diff", Diff, 32'd0);

    // Directed cases.
    do_op("3-1", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3 + DONE_CYC);
    do_op("1-0.75", 32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 5 + DONE_CYC);
    e = ref_sub(32'hC000_0000, 32'h4040_0000, lat);
    do_op("-2-3", 32'hC000_0000, 32'h4040_0000, 32'hC0A0_0000, lat);
    e = ref_sub(32'h3F80_0000, 32'h3F80_0000, lat);
    do_op("1-1", 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, lat);
    e = ref_sub(32'h3F80_0000, 32'h3080_0000, lat);
    do_op("1-tiny", 32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, lat);
    e = ref_sub(32'h0000_0000, 32'h0000_0000, lat);
    do_op("0-0", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, lat);
    e = ref_sub(32'h7F7F_FFFF, 32'hFF7F_FFFF, lat);
    do_op("overflow", 32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, lat);
    e = ref_sub(32'h0080_0000, 32'h00C0_0000, lat);
    do_op("underflow", 32'h0080_0000, 32'h00C0_0000, 32'h0000_0000, lat);

    // in_valid held with new operands while busy: only the first pair runs.
    InA = 32'h4040_0000;
    InB = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    InA = 32'h4120_0000;
    InB = 32'h3F00_0000;
    n = 0;
    bad = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      if (in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("busy ready low", 32'(bad), 32'd0);
    check("busy latency", 32'(n), 32'(3 + DONE_CYC));
    check("busy diff", Diff, 32'h4000_0000);
    check("busy ready back", {31'd0, in_ready}, 32'd1);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    check("busy not queued", 32'(bad), 32'd0);

    // Reset in the middle of NORM for 1.0 - 0.75.
    InA = 32'h3F80_0000;
    InB = 32'h3F40_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid reset diff", Diff, 32'd0);
    check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    check("mid reset no result", 32'(bad), 32'd0);
    do_op("after reset", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3 + DONE_CYC);

    // Randomized operands against the reference model.
    for (int i = 0; i < 48; i++) begin
      ea = int'($urandom_range(EXP_BIAS + 20, EXP_BIAS - 20));
      a  = {1'($urandom), 8'(ea), 23'($urandom)};
      case (i % 4)
        0: b = {1'($urandom), 8'($urandom_range(EXP_BIAS + 20, EXP_BIAS - 20)), 23'($urandom)};
        1: b = {1'($urandom), a[30:23], a[22:0] ^ 23'($urandom_range(255, 0))};
        2: begin
          a[30:23] = 8'($urandom_range(3, 1));
          b = {1'($urandom), a[30:23] + 8'($urandom_range(1, 0)), 23'($urandom)};
        end
        default: b = {1'($urandom), 8'(ea - int'($urandom_range(30, 0))), 23'($urandom)};
      endcase
      e = ref_sub(a, b, lat);
      do_op($sformatf("rnd%0d", i), a, b, e, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
